// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// Tag/word widths match the core's register-file definitions.
package regfile_wb_arbiter_pkg;

    localparam int unsigned TAG_W           = 5;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned WB_FIFO_DEPTH   = 4;
    localparam int unsigned WB_STARVE_LIMIT = 8;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        tag_t  rd;
        word_t value;
        logic  live;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_A,
        SEL_HEAD
    } wb_sel_e;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Buffer for long-latency writeback results: {rd,value,live} entries with
// kill-by-tag and two live-entry tag-match outputs for hazard detection.
module regfile_wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    input  logic                       kill,
    input  tag_t                       kill_rd,
    input  tag_t                       match_rd_1,
    input  tag_t                       match_rd_2,
    output wb_entry_t                  head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       match_1,
    output logic                       match_2
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Popped slots have live cleared so matches never see stale entries.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (kill) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (entries[i].rd == kill_rd) begin
                        entries[i].live <= 1'b0;
                    end
                end
            end
            if (pop) begin
                entries[rd_ptr].live <= 1'b0;
                rd_ptr               <= rd_ptr + 1'b1;
            end
            if (push) begin
                entries[wr_ptr] <= push_entry;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        match_1 = 1'b0;
        match_2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries[i].live && (entries[i].rd == match_rd_1)) match_1 = 1'b1;
            if (entries[i].live && (entries[i].rd == match_rd_2)) match_2 = 1'b1;
        end
    end

    assign head  = entries[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the main pipeline
// (fixed priority) and buffered long-latency results, with starvation relief.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = WB_FIFO_DEPTH,
    parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       a_valid,
    input  logic                       a_write_rd,
    input  tag_t                       a_rd,
    input  word_t                      a_value,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  tag_t                       b_rd,
    input  word_t                      b_value,
    output logic                       stall_a,
    output logic                       wr_valid,
    output logic                       wr_write_rd,
    output tag_t                       wr_rd,
    output word_t                      wr_value,
    input  tag_t                       q_rs1,
    input  tag_t                       q_rs2,
    output logic                       q_rs1_pending,
    output logic                       q_rs2_pending,
    output logic [$clog2(DEPTH+1)-1:0] b_count
);

    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] LIMIT_COUNT = SC_W'(STARVE_LIMIT);

    logic      a_write;
    logic      push;
    logic      pop;
    wb_entry_t push_entry;
    wb_entry_t head;
    logic      fifo_empty;
    logic      fifo_full;
    logic      match_1;
    logic      match_2;
    wb_sel_e   sel;
    logic [SC_W-1:0] starve_cnt;

    assign a_write = a_valid & a_write_rd & (a_rd != '0);
    assign b_ready = ~fifo_full;
    assign push    = b_valid & b_ready & (b_rd != '0);

    // B results are older than A, so a same-cycle A write to the same tag
    // makes the incoming entry obsolete before it is stored.
    assign push_entry = '{rd: b_rd, value: b_value, live: ~(a_write && (a_rd == b_rd))};

    always_comb begin
        sel = SEL_NONE;
        if (a_write) begin
            sel = SEL_A;
        end else if (!fifo_empty) begin
            sel = SEL_HEAD;
        end
    end

    assign pop = (sel == SEL_HEAD);

    regfile_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill       (a_write),
        .kill_rd    (a_rd),
        .match_rd_1 (q_rs1),
        .match_rd_2 (q_rs2),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (b_count),
        .match_1    (match_1),
        .match_2    (match_2)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (pop) begin
            starve_cnt <= '0;
        end else if (!fifo_empty && head.live && (starve_cnt != LIMIT_COUNT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign stall_a = (starve_cnt == LIMIT_COUNT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_valid    <= 1'b0;
            wr_write_rd <= 1'b0;
            wr_rd       <= '0;
            wr_value    <= '0;
        end else begin
            wr_valid    <= 1'b0;
            wr_write_rd <= 1'b0;
            wr_rd       <= '0;
            wr_value    <= '0;
            case (sel)
                SEL_A: begin
                    wr_valid    <= 1'b1;
                    wr_write_rd <= 1'b1;
                    wr_rd       <= a_rd;
                    wr_value    <= a_value;
                end
                SEL_HEAD: begin
                    if (head.live) begin
                        wr_valid    <= 1'b1;
                        wr_write_rd <= 1'b1;
                        wr_rd       <= head.rd;
                        wr_value    <= head.value;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q_rs1_pending = (q_rs1 != '0) & (match_1 | (wr_write_rd & (wr_rd == q_rs1)));
    assign q_rs2_pending = (q_rs2 != '0) & (match_2 | (wr_write_rd & (wr_rd == q_rs2)));

    a_valid_during_stall: assert property (@(posedge clock) disable iff (!reset_n)
        stall_a |-> !a_valid);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-cycle expected write-port
// values are queued at drive time and compared one cycle later.
module tb_regfile_wb_arbiter;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic        v;
        logic        w;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
        logic        live;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_write_rd = 1'b0;
    logic [4:0]  a_rd = '0;
    logic [31:0] a_value = '0;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [4:0]  b_rd = '0;
    logic [31:0] b_value = '0;
    logic        stall_a;
    logic        wr_valid;
    logic        wr_write_rd;
    logic [4:0]  wr_rd;
    logic [31:0] wr_value;
    logic [4:0]  q_rs1 = '0;
    logic [4:0]  q_rs2 = '0;
    logic        q_rs1_pending;
    logic        q_rs2_pending;
    logic [2:0]  b_count;

    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];
    ent_t        model[$];
    logic [31:0] rf [32];

    regfile_wb_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_LIMIT(8)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .a_valid       (a_valid),
        .a_write_rd    (a_write_rd),
        .a_rd          (a_rd),
        .a_value       (a_value),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .b_rd          (b_rd),
        .b_value       (b_value),
        .stall_a       (stall_a),
        .wr_valid      (wr_valid),
        .wr_write_rd   (wr_write_rd),
        .wr_rd         (wr_rd),
        .wr_value      (wr_value),
        .q_rs1         (q_rs1),
        .q_rs2         (q_rs2),
        .q_rs1_pending (q_rs1_pending),
        .q_rs2_pending (q_rs2_pending),
        .b_count       (b_count)
    );

    always #5 clock = ~clock;

    // Scoreboard: one expected write-port value per driven cycle.
    always @(posedge clock) begin
        exp_t e;
        exp_t got;
        #1;
        if (reset_n) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            got = '{v: wr_valid, w: wr_write_rd, rd: wr_rd, val: wr_value};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL wr_port: got v=%0b w=%0b rd=%0d val=%h, expected v=%0b w=%0b rd=%0d val=%h",
                         got.v, got.w, got.rd, got.val, e.v, e.w, e.rd, e.val);
            end
            if (wr_valid && wr_write_rd) rf[wr_rd] = wr_value;
        end
    end

    // Applies one cycle of stimulus and advances the reference model.
    task automatic drive(input logic av, input logic awr, input logic [4:0] ard, input logic [31:0] aval,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bval);
        exp_t e;
        ent_t n;
        logic awrite;
        int   cnt0;
        a_valid = av; a_write_rd = awr; a_rd = ard; a_value = aval;
        b_valid = bv; b_rd = brd; b_value = bval;
        if (!reset_n) return;
        cnt0   = model.size();
        awrite = av && awr && (ard != 5'd0);
        e      = '0;
        if (awrite) begin
            e = '{v: 1'b1, w: 1'b1, rd: ard, val: aval};
            foreach (model[i]) if (model[i].rd == ard) model[i].live = 1'b0;
        end else if (model.size() > 0) begin
            n = model.pop_front();
            if (n.live) e = '{v: 1'b1, w: 1'b1, rd: n.rd, val: n.val};
        end
        if (bv && (cnt0 < DEPTH) && (brd != 5'd0)) begin
            n.rd = brd; n.val = bval; n.live = !(awrite && (ard == brd));
            model.push_back(n);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({wr_valid, wr_write_rd, wr_rd, wr_value} !== '0) begin
            n_fail++; $display("FAIL reset_wr: got %h, expected 0", {wr_valid, wr_write_rd, wr_rd, wr_value});
        end
        n_checks++;
        if (b_count !== 3'd0 || b_ready !== 1'b1 || stall_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl: got count=%0d ready=%0b stall=%0b, expected 0/1/0", b_count, b_ready, stall_a);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        idle();
    endtask

    task automatic test_a_only();
        @(negedge clock);
        drive(1'b1, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        drive(1'b1, 1'b1, 5'd0, 32'h22, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        drive(1'b1, 1'b0, 5'd6, 32'h33, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        drive(1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        idle();
    endtask

    task automatic test_contention();
        @(negedge clock);
        n_checks++;
        if (stall_a !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got %0b, expected 0", stall_a); end
        drive(1'b1, 1'b1, 5'd8, 32'h1000, 1'b1, 5'd7, 32'hAA);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            n_checks++;
            if (stall_a !== 1'b0) begin n_fail++; $display("FAIL stall_early: cycle %0d got %0b, expected 0", i, stall_a); end
            drive(1'b1, 1'b1, 5'(8 + i), 32'h1000 + i, 1'b0, 5'd0, 32'd0);
        end
        @(negedge clock);
        n_checks++;
        if (stall_a !== 1'b1) begin n_fail++; $display("FAIL stall_pulse: got %0b, expected 1", stall_a); end
        idle();
        @(negedge clock);
        n_checks++;
        if (stall_a !== 1'b0 || b_count !== 3'd0) begin
            n_fail++; $display("FAIL stall_after: got stall=%0b count=%0d, expected 0/0", stall_a, b_count);
        end
        idle();
    endtask

    task automatic test_waw();
        @(negedge clock);
        drive(1'b1, 1'b1, 5'd1, 32'h100, 1'b1, 5'd3, 32'h1);
        @(negedge clock);
        drive(1'b1, 1'b1, 5'd2, 32'h200, 1'b1, 5'd3, 32'h2);
        @(negedge clock);
        q_rs1 = 5'd3;
        #1;
        n_checks++;
        if (q_rs1_pending !== 1'b1) begin n_fail++; $display("FAIL waw_pend_queued: got %0b, expected 1", q_rs1_pending); end
        drive(1'b1, 1'b1, 5'd3, 32'h9, 1'b0, 5'd0, 32'd0);
        @(negedge clock);
        #1;
        n_checks++;
        if (q_rs1_pending !== 1'b1 || b_count !== 3'd2) begin
            n_fail++; $display("FAIL waw_pend_wr: got pend=%0b count=%0d, expected 1/2", q_rs1_pending, b_count);
        end
        idle();
        @(negedge clock);
        #1;
        n_checks++;
        if (q_rs1_pending !== 1'b0) begin n_fail++; $display("FAIL waw_pend_dead: got %0b, expected 0", q_rs1_pending); end
        idle();
        @(negedge clock);
        #1;
        n_checks++;
        if (q_rs1_pending !== 1'b0 || b_count !== 3'd0 || rf[3] !== 32'h9) begin
            n_fail++; $display("FAIL waw_final: got pend=%0b count=%0d x3=%h, expected 0/0/9", q_rs1_pending, b_count, rf[3]);
        end
        q_rs1 = 5'd0;
        idle();
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_checks++;
            if (b_ready !== 1'b1 || b_count !== 3'(i)) begin
                n_fail++; $display("FAIL fill: got ready=%0b count=%0d, expected 1/%0d", b_ready, b_count, i);
            end
            drive(1'b1, 1'b1, 5'(20 + i), 32'(i), 1'b1, 5'(12 + i), 32'hB0 + i);
        end
        @(negedge clock);
        n_checks++;
        if (b_ready !== 1'b0 || b_count !== 3'd4) begin
            n_fail++; $display("FAIL full: got ready=%0b count=%0d, expected 0/4", b_ready, b_count);
        end
        drive(1'b1, 1'b1, 5'd24, 32'd4, 1'b1, 5'd16, 32'hB4);
        @(negedge clock);
        n_checks++;
        if (b_count !== 3'd4) begin n_fail++; $display("FAIL full_hold: got count=%0d, expected 4", b_count); end
        idle();
        @(negedge clock);
        n_checks++;
        if (b_count !== 3'd3) begin n_fail++; $display("FAIL pop_one: got count=%0d, expected 3", b_count); end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd17, 32'hB5);
        @(negedge clock);
        n_checks++;
        if (b_count !== 3'd3 || b_ready !== 1'b1) begin
            n_fail++; $display("FAIL push_pop: got count=%0d ready=%0b, expected 3/1", b_count, b_ready);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            idle();
        end
        @(negedge clock);
        n_checks++;
        if (b_count !== 3'd0) begin n_fail++; $display("FAIL drain: got count=%0d, expected 0", b_count); end
        idle();
    endtask

    task automatic test_pending();
        logic exp2 [4];
        exp2[0] = 1'b0; exp2[1] = 1'b1; exp2[2] = 1'b1; exp2[3] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            q_rs1 = 5'd0;
            q_rs2 = 5'd10;
            #1;
            n_checks++;
            if (q_rs2_pending !== exp2[c] || q_rs1_pending !== 1'b0) begin
                n_fail++; $display("FAIL pending: cycle %0d got rs1=%0b rs2=%0b, expected 0/%0b",
                                   c, q_rs1_pending, q_rs2_pending, exp2[c]);
            end
            if (c == 0) drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h55);
            else        idle();
        end
        q_rs2 = 5'd0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            drive(1'b1, 1'b1, 5'(1 + i), 32'h300 + i, 1'b1, 5'(20 + i), 32'h400 + i);
        end
        @(negedge clock);
        n_checks++;
        if (b_count !== 3'd3) begin n_fail++; $display("FAIL mid_queued: got count=%0d, expected 3", b_count); end
        reset_n = 1'b0;
        model.delete();
        exp_q.delete();
        idle();
        q_rs1 = 5'd20;
        #1;
        n_checks++;
        if ({wr_valid, wr_write_rd, wr_rd, wr_value} !== '0 || stall_a !== 1'b0 || q_rs1_pending !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_out: got wr=%h stall=%0b pend=%0b, expected 0",
                               {wr_valid, wr_write_rd, wr_rd, wr_value}, stall_a, q_rs1_pending);
        end
        n_checks++;
        if (b_count !== 3'd0 || b_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_fifo: got count=%0d ready=%0b, expected 0/1", b_count, b_ready);
        end
        q_rs1 = 5'd0;
        @(negedge clock);
        reset_n = 1'b1;
        idle();
        @(negedge clock);
        n_checks++;
        if (b_count !== 3'd0) begin n_fail++; $display("FAIL mid_after: got count=%0d, expected 0", b_count); end
        idle();
    endtask

    initial begin
        foreach (rf[i]) rf[i] = '0;
        test_reset();
        test_a_only();
        test_contention();
        test_waw();
        test_full();
        test_pending();
        test_reset_mid();
        @(posedge clock);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
